// File: rtl/ps2_tx_multi_if.sv
// Bundle of the host-side write port and the per-channel PS/2 line/status signals.
//   master : drives wr_strobe/wr_ch/wr_data/flush, observes line and status outputs
//   slave  : the transmitter; receives writes/flushes, drives ps2_clk/ps2_data/busy/
//            fifo_full/overflow
// NCH must match the NCH of the ps2_tx_multi instance the interface is bound to.
interface ps2_tx_multi_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
);
    logic           wr_strobe;
    logic [CHW-1:0] wr_ch;
    logic [7:0]     wr_data;
    logic [NCH-1:0] flush;
    logic [NCH-1:0] ps2_clk;
    logic [NCH-1:0] ps2_data;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] fifo_full;
    logic [NCH-1:0] overflow;

    modport master (
        output wr_strobe, wr_ch, wr_data, flush,
        input  ps2_clk, ps2_data, busy, fifo_full, overflow
    );

    modport slave (
        input  wr_strobe, wr_ch, wr_data, flush,
        output ps2_clk, ps2_data, busy, fifo_full, overflow
    );
endinterface

// File: rtl/ps2_tx_multi.sv
// Multi-channel PS/2 device-side transmitter. Each of NCH channels owns a byte FIFO
// and an 11-bit frame sequencer (start, 8 data LSB first, odd parity, stop). All
// channels share one clock divider, so concurrent frames are bit-aligned.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of ps2_tx_multi_if (write port, flush, PS/2 lines, status)
module ps2_tx_multi #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned FIFO_BITS = 3,
    parameter int unsigned CLK_DIV   = 1000
) (
    input logic           clk,
    input logic           reset,
    ps2_tx_multi_if.slave bus
);
    localparam int unsigned Depth = 2 ** FIFO_BITS;
    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned ChW   = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [DivW-1:0]    DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0]    DivOne  = DivW'(1);
    localparam logic [FIFO_BITS:0] PtrOne  = (FIFO_BITS + 1)'(1);
    localparam logic [FIFO_BITS:0] PtrFull = {1'b1, {FIFO_BITS{1'b0}}};

    // State n (1..8) drives data bit n-1 at its rise event.
    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StBit0   = 4'd1,
        StBit1   = 4'd2,
        StBit2   = 4'd3,
        StBit3   = 4'd4,
        StBit4   = 4'd5,
        StBit5   = 4'd6,
        StBit6   = 4'd7,
        StBit7   = 4'd8,
        StParity = 4'd9,
        StStop   = 4'd10,
        StEnd    = 4'd11
    } state_e;

    logic [DivW-1:0]    div_q;
    logic               phase_q;
    state_e             state_q  [NCH];
    logic [7:0]         shreg_q  [NCH];
    logic [FIFO_BITS:0] wr_ptr_q [NCH];
    logic [FIFO_BITS:0] rd_ptr_q [NCH];
    logic [7:0]         mem_q    [NCH][Depth];
    logic [NCH-1:0]     data_q;
    logic [NCH-1:0]     ovf_q;

    logic           tc;
    logic           rise;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] full;
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] bit_sel;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] busy_out;

    always_comb begin
        tc   = (div_q == DivLast);
        rise = tc & ~phase_q;
        for (int unsigned n = 0; n < NCH; n++) begin
            empty[n]    = (wr_ptr_q[n] == rd_ptr_q[n]);
            full[n]     = ((wr_ptr_q[n] ^ rd_ptr_q[n]) == PtrFull);
            // Out-of-range wr_ch matches no channel, so it is silently ignored.
            wr_hit[n]   = bus.wr_strobe && (bus.wr_ch == ChW'(n));
            bit_sel[n]  = shreg_q[n][3'(state_q[n] - 4'd1)];
            clk_out[n]  = phase_q | (state_q[n] == StIdle);
            busy_out[n] = (state_q[n] != StIdle);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            data_q  <= '1;
            ovf_q   <= '0;
            for (int unsigned n = 0; n < NCH; n++) begin
                state_q[n]  <= StIdle;
                shreg_q[n]  <= '0;
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
            end
        end else begin
            if (tc) begin
                div_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                div_q <= div_q + DivOne;
            end

            for (int unsigned n = 0; n < NCH; n++) begin
                // FIFO: flush wins over both a write and a pop in the same cycle.
                if (bus.flush[n]) begin
                    wr_ptr_q[n] <= '0;
                    rd_ptr_q[n] <= '0;
                    ovf_q[n]    <= 1'b0;
                end else begin
                    if (wr_hit[n]) begin
                        // Fullness is judged before any same-cycle pop.
                        if (full[n]) begin
                            ovf_q[n] <= 1'b1;
                        end else begin
                            mem_q[n][wr_ptr_q[n][FIFO_BITS-1:0]] <= bus.wr_data;
                            wr_ptr_q[n] <= wr_ptr_q[n] + PtrOne;
                        end
                    end
                    if (rise && state_q[n] == StIdle && !empty[n]) begin
                        rd_ptr_q[n] <= rd_ptr_q[n] + PtrOne;
                    end
                end

                // Frame sequencer: advances and changes data only on rise events.
                if (rise) begin
                    unique case (state_q[n])
                        StIdle: begin
                            if (!empty[n]) begin
                                shreg_q[n] <= mem_q[n][rd_ptr_q[n][FIFO_BITS-1:0]];
                                data_q[n]  <= 1'b0;
                                state_q[n] <= StBit0;
                            end
                        end
                        StBit0, StBit1, StBit2, StBit3, StBit4, StBit5, StBit6, StBit7: begin
                            data_q[n]  <= bit_sel[n];
                            state_q[n] <= state_e'(state_q[n] + 4'd1);
                        end
                        StParity: begin
                            data_q[n]  <= ~^shreg_q[n];
                            state_q[n] <= StStop;
                        end
                        StStop: begin
                            data_q[n]  <= 1'b1;
                            state_q[n] <= StEnd;
                        end
                        StEnd: begin
                            data_q[n]  <= 1'b1;
                            state_q[n] <= StIdle;
                        end
                        default: begin
                            data_q[n]  <= 1'b1;
                            state_q[n] <= StIdle;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.ps2_clk   = clk_out;
    assign bus.ps2_data  = data_q;
    assign bus.busy      = busy_out;
    assign bus.fifo_full = full;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_ps2_tx_multi.sv
// Bench for ps2_tx_multi: NCH=3 (so wr_ch=3 is out of range), FIFO depth 8, CLK_DIV=16.
// Passive host-style receivers sample ps2_data on each falling ps2_clk edge and
// collect 11-bit frames; these are compared against frames built from the written
// bytes (start 0, data LSB first, odd parity, stop 1).
module tb_ps2_tx_multi;
    localparam int unsigned Nch   = 3;
    localparam int unsigned Div   = 16;
    localparam int          Frame = 12 * 2 * Div;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_tx_multi_if #(.NCH(Nch)) bus ();

    ps2_tx_multi #(.NCH(Nch), .FIFO_BITS(3), .CLK_DIV(Div)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Host receivers, one per channel.
    logic [10:0] sh0, sh1, sh2;
    int          cnt0 = 0, cnt1 = 0, cnt2 = 0;
    int          nf0 = 0, nf1 = 0, nf2 = 0;
    time         st0, st1, st2;
    logic [10:0] rxq0[$], rxq1[$], rxq2[$];
    time         rxt0[$], rxt1[$], rxt2[$];

    always @(negedge bus.ps2_clk[0] or posedge reset) begin
        if (reset) cnt0 = 0;
        else begin
            sh0 = {bus.ps2_data[0], sh0[10:1]};
            if (cnt0 == 0) st0 = $time;
            nf0++; cnt0++;
            if (cnt0 == 11) begin rxq0.push_back(sh0); rxt0.push_back(st0); cnt0 = 0; end
        end
    end
    always @(negedge bus.ps2_clk[1] or posedge reset) begin
        if (reset) cnt1 = 0;
        else begin
            sh1 = {bus.ps2_data[1], sh1[10:1]};
            if (cnt1 == 0) st1 = $time;
            nf1++; cnt1++;
            if (cnt1 == 11) begin rxq1.push_back(sh1); rxt1.push_back(st1); cnt1 = 0; end
        end
    end
    always @(negedge bus.ps2_clk[2] or posedge reset) begin
        if (reset) cnt2 = 0;
        else begin
            sh2 = {bus.ps2_data[2], sh2[10:1]};
            if (cnt2 == 0) st2 = $time;
            nf2++; cnt2++;
            if (cnt2 == 11) begin rxq2.push_back(sh2); rxt2.push_back(st2); cnt2 = 0; end
        end
    end

    function automatic int rx_size(int ch);
        case (ch)
            0: return rxq0.size();
            1: return rxq1.size();
            default: return rxq2.size();
        endcase
    endfunction

    function automatic logic [10:0] rx_get(int ch, int idx);
        case (ch)
            0: return rxq0[idx];
            1: return rxq1[idx];
            default: return rxq2[idx];
        endcase
    endfunction

    function automatic time rx_time(int ch, int idx);
        case (ch)
            0: return rxt0[idx];
            1: return rxt1[idx];
            default: return rxt2[idx];
        endcase
    endfunction

    function automatic int n_falls(int ch);
        case (ch)
            0: return nf0;
            1: return nf1;
            default: return nf2;
        endcase
    endfunction

    // Reference frame: bit 0 is the first bit on the wire.
    function automatic logic [10:0] encode(logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Expected byte stream per channel, and receiver positions at test start.
    logic [7:0] exp_b [Nch][8];
    int         exp_n [Nch];
    int         rx_base [Nch];
    int         nf_base [Nch];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Leaves reset deasserted just after an edge; the divider's first rise event
    // then falls 16 edges later.
    task automatic start_test();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < Nch; c++) begin
            exp_n[c]   = 0;
            rx_base[c] = rx_size(c);
            nf_base[c] = n_falls(c);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        bus.wr_strobe = 1'b1;
        bus.wr_ch     = ch;
        bus.wr_data   = d;
        tick();
        bus.wr_strobe = 1'b0;
    endtask

    task automatic expect_byte(input int ch, input logic [7:0] d);
        exp_b[ch][exp_n[ch]] = d;
        exp_n[ch]++;
    endtask

    task automatic check_frames(input int ch);
        int got;
        got = rx_size(ch) - rx_base[ch];
        chk($sformatf("frame_count_ch%0d", ch), 32'(got), 32'(exp_n[ch]));
        for (int i = 0; i < exp_n[ch] && i < got; i++)
            chk($sformatf("frame_bits_ch%0d_%0d", ch, i),
                32'(rx_get(ch, rx_base[ch] + i)), 32'(encode(exp_b[ch][i])));
    endtask

    logic [7:0] byt [9];
    int         c;
    logic [7:0] d;

    initial begin
        bus.wr_strobe = 1'b0;
        bus.wr_ch     = '0;
        bus.wr_data   = '0;
        bus.flush     = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_ps2_clk", 32'(bus.ps2_clk), 32'h7);
        chk("rst_ps2_data", 32'(bus.ps2_data), 32'h7);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_fifo_full", 32'(bus.fifo_full), 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);

        // Single frame 0x1C on ch0.
        start_test();
        wr(2'd0, 8'h1C);
        expect_byte(0, 8'h1C);
        idle(40);
        chk("frame_busy", 32'(bus.busy[0]), 32'h1);
        idle(Frame + 40);
        check_frames(0);
        if (rx_size(0) > rx_base[0])
            chk("frame_1c_raw", 32'(rx_get(0, rx_base[0])), 32'(11'b10000111000));
        chk("frame_idle_data", 32'(bus.ps2_data[0]), 32'h1);
        chk("frame_idle_busy", 32'(bus.busy[0]), 32'h0);
        chk("frame_ch1_clk_quiet", 32'(n_falls(1) - nf_base[1]), 32'h0);

        // Overflow: nine back-to-back writes to ch1 before the first rise event.
        start_test();
        for (int i = 0; i < 9; i++) byt[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            wr(2'd1, byt[i]);
            expect_byte(1, byt[i]);
        end
        chk("ovf_full_after_8", 32'(bus.fifo_full[1]), 32'h1);
        chk("ovf_flag_before_9", 32'(bus.overflow[1]), 32'h0);
        wr(2'd1, byt[8]);
        chk("ovf_flag_after_9", 32'(bus.overflow[1]), 32'h1);
        chk("ovf_other_ch", 32'({bus.overflow[0], bus.overflow[2], bus.fifo_full[0]}), 32'h0);
        idle(8 * Frame + 100);
        check_frames(1);
        chk("ovf_drained_full", 32'(bus.fifo_full[1]), 32'h0);
        chk("ovf_sticky", 32'(bus.overflow[1]), 32'h1);

        // Concurrency: frames on ch0 and ch1 start on the same rise event.
        start_test();
        wr(2'd0, 8'hAA);
        wr(2'd1, 8'h55);
        expect_byte(0, 8'hAA);
        expect_byte(1, 8'h55);
        idle(Frame + 80);
        check_frames(0);
        check_frames(1);
        if (rx_size(0) > rx_base[0] && rx_size(1) > rx_base[1]) begin
            chk("conc_start_aligned", 32'(rx_time(0, rx_base[0])), 32'(rx_time(1, rx_base[1])));
            chk("conc_parity_aa", 32'(rx_get(0, rx_base[0]) >> 9) & 32'h1, 32'h1);
            chk("conc_parity_55", 32'(rx_get(1, rx_base[1]) >> 9) & 32'h1, 32'h1);
        end

        // Flush with a simultaneous write while a frame is in flight.
        start_test();
        for (int i = 0; i < 9; i++) begin
            byt[i] = 8'($urandom);
            wr(2'd0, byt[i]);
        end
        expect_byte(0, byt[0]);
        chk("flush_pre_overflow", 32'(bus.overflow[0]), 32'h1);
        idle(90);
        bus.flush[0]  = 1'b1;
        bus.wr_strobe = 1'b1;
        bus.wr_ch     = 2'd0;
        bus.wr_data   = 8'h3C;
        tick();
        bus.flush[0]  = 1'b0;
        bus.wr_strobe = 1'b0;
        chk("flush_ovf_cleared", 32'(bus.overflow[0]), 32'h0);
        chk("flush_not_full", 32'(bus.fifo_full[0]), 32'h0);
        chk("flush_frame_running", 32'(bus.busy[0]), 32'h1);
        idle(4 * Frame);
        check_frames(0);
        chk("flush_ovf_final", 32'(bus.overflow[0]), 32'h0);

        // Reset in state 5 with two bytes still queued.
        start_test();
        wr(2'd0, 8'h12);
        wr(2'd0, 8'h34);
        wr(2'd0, 8'h56);
        idle(147);
        chk("rst_mid_busy_before", 32'(bus.busy[0]), 32'h1);
        reset = 1'b1;
        tick();
        chk("rst_mid_clk", 32'(bus.ps2_clk[0]), 32'h1);
        chk("rst_mid_data", 32'(bus.ps2_data[0]), 32'h1);
        chk("rst_mid_busy", 32'(bus.busy[0]), 32'h0);
        reset = 1'b0;
        rx_base[0] = rx_size(0);
        idle(3 * Frame);
        chk("rst_mid_no_frames", 32'(rx_size(0) - rx_base[0]), 32'h0);
        chk("rst_mid_idle_busy", 32'(bus.busy), 32'h0);

        // Out-of-range channel: nine writes to wr_ch=3 leave everything idle.
        start_test();
        for (int i = 0; i < 9; i++) wr(2'd3, 8'($urandom));
        chk("inv_full", 32'(bus.fifo_full), 32'h0);
        chk("inv_overflow", 32'(bus.overflow), 32'h0);
        idle(Frame);
        chk("inv_no_activity",
            32'((n_falls(0) - nf_base[0]) + (n_falls(1) - nf_base[1]) + (n_falls(2) - nf_base[2])),
            32'h0);

        // Random traffic across all channels, including out-of-range writes.
        for (int r = 0; r < 3; r++) begin
            start_test();
            for (int i = 0; i < 20; i++) begin
                c = int'($urandom_range(0, 3));
                d = 8'($urandom);
                if (c == 3) wr(2'd3, d);
                else if (exp_n[c] < 8) begin
                    expect_byte(c, d);
                    wr(2'(c), d);
                end else tick();
            end
            idle(8 * Frame + 300);
            chk("rand_overflow", 32'(bus.overflow), 32'h0);
            for (int ch = 0; ch < Nch; ch++) check_frames(ch);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_tx_multi.md
PS2_TX_MULTI -- requirements
Module: ps2_tx_multi

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent PS/2 device-side transmit channels (1..8).
REQ-002 SHALL have parameter FIFO_BITS, default 3, giving a per-channel FIFO depth of 2**FIFO_BITS bytes.
REQ-003 SHALL have parameter CLK_DIV, default 1000, giving the PS/2 half-period in clk cycles (minimum 2).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wr_strobe, input, 1, a one-cycle write request.
REQ-007 SHALL have port wr_ch, input, max(1,clog2(NCH)), the target channel of the write.
REQ-008 SHALL have port wr_data, input, 8, the byte to queue.
REQ-009 SHALL have port flush, input, NCH, a per-channel FIFO clear request.
REQ-010 SHALL have port ps2_clk, output, NCH, the per-channel PS/2 clock.
REQ-011 SHALL have port ps2_data, output, NCH, the per-channel PS/2 data line.
REQ-012 SHALL have port busy, output, NCH, high while the channel's frame state is non-zero.
REQ-013 SHALL have port fifo_full, output, NCH, high when the channel FIFO holds 2**FIFO_BITS entries.
REQ-014 SHALL have port overflow, output, NCH, a sticky flag set when a write is dropped.

Function
REQ-015 SHALL implement a shared divider counting 0..CLK_DIV-1 that toggles a shared phase bit at terminal count; a "rise event" is a terminal-count cycle in which phase is 0.
REQ-016 SHALL drive ps2_clk[n] = phase OR (state[n]==0), so the clock is held high while the channel is idle.
REQ-017 SHALL give each channel a frame state 0..11 that advances only on rise events.
REQ-018 In state 0 at a rise event with the FIFO non-empty, SHALL load the head byte, pop it, drive data 0 (start bit), and go to state 1.
REQ-019 In states 1..8 at a rise event, SHALL drive data bits LSB first, with bit (state-1).
REQ-020 In state 9, SHALL drive odd parity, i.e. the XNOR-reduction of the byte.
REQ-021 In state 10, SHALL drive the stop bit 1.
REQ-022 In state 11, SHALL hold data at 1 and return to state 0; a frame therefore occupies 12 rise events.
REQ-023 SHALL change data only on rise events; the host samples on the falling edge of ps2_clk.
REQ-024 SHALL address each FIFO with pointers of FIFO_BITS+1 bits: empty when the pointers are equal, full when only their MSBs differ.
REQ-025 SHALL store a write (wr_strobe=1) only into channel wr_ch; wr_ch >= NCH SHALL be ignored without setting any flag.
REQ-026 SHALL drop a write to a channel that is full at the start of the cycle (a same-cycle pop does not admit it) and set overflow for that channel.
REQ-027 SHALL, on flush[n], zero both pointers and clear overflow[n]; a flush and a write to n in the same cycle SHALL drop the write without setting overflow.
REQ-028 SHALL let a flush leave an in-flight frame running to state 0 unaltered.
REQ-029 SHALL treat a pop and a write in the same cycle on a non-full FIFO as both taking effect.
REQ-030 SHALL transmit all channels on common rise events, so concurrent frames are bit-aligned.

Reset
REQ-031 SHALL, while reset is high, force divider=0, phase=0, all states 0, all pointers 0, ps2_clk all 1, ps2_data all 1, busy 0, overflow 0, fifo_full 0.
REQ-032 A reset asserted mid-frame SHALL abort the frame and discard queued bytes, with outputs idle in the next cycle.

Verification
REQ-033 Test frame encoding: CLK_DIV=4, write 0x1C to ch0 -> ps2_data[0] across successive rise events is 0,0,0,1,1,1,0,0,0,0,1, then idle high; ps2_clk[1] stays 1.
REQ-034 Test overflow: CLK_DIV=1000, FIFO_BITS=3, 9 back-to-back writes to ch1 from cycle 1 -> fifo_full[1]=1 after the 8th write, 9th write dropped, overflow[1]=1; 8 frames follow.
REQ-035 Test concurrency: writes of 0xAA to ch0 and 0x55 to ch1 on consecutive cycles -> both start bits on the same rise event, with parity 1 for both.
REQ-036 Test flush: flush[0] with a simultaneous write while 3 bytes are queued and a frame is in flight -> the current frame completes, no further frames, overflow[0]=0.
REQ-037 Test reset: reset in state 5 with 2 bytes queued -> next cycle ps2_clk=1, ps2_data=1, busy=0, and no frames after reset deasserts.
REQ-038 Test invalid channel: NCH=2, write with wr_ch=3 -> no FIFO change and no flags on any channel.
